// File: rtl/alu_result_fifo.sv
// alu_result_fifo: result FIFO sitting behind the 8-bit ALU.
//
// Captures each ALU result F together with its six status flags. A slower
// consumer drains the entries through a valid/ready handshake. The head
// entry is presented show-ahead and reads as zero while the FIFO is empty.
// A push attempted while the FIFO is full is dropped and sets the sticky
// overrun flag.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   in_valid   ALU result valid this cycle
//   in_ready   FIFO can accept a push (!full)
//   F          ALU result word
//   in_flags   {A_bigger, B_bigger, A_equal_B, flag_zero, carry_out, over_flow}
//   out_valid  head entry available (!empty)
//   out_ready  consumer accepts the head entry
//   out_data   head result (0 when empty)
//   out_flags  head flags (0 when empty)
//   count      occupied entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overrun    sticky: a push was attempted while full
//   clr_err    synchronous clear of overrun and of the stats counters
//   carry_cnt  accepted entries with carry_out=1 (saturating)
//   ovf_cnt    accepted entries with over_flow=1 (saturating)
//
// Optional feature: define ALU_FLAG_STATS_EN to build the carry/overflow
// counters. Without it, carry_cnt and ovf_cnt are tied to zero.

module alu_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] F,
  input  logic [5:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_flags,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  input  logic              clr_err,
  output logic [7:0]        carry_cnt,
  output logic [7:0]        ovf_cnt
);

  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

  logic [DATA_W+5:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overrun;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [DATA_W+5:0] w_head;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  // Acceptance depends on the current full state only; a same-cycle pop
  // does not make room for a push.
  assign w_push  = in_valid & ~w_full;
  assign w_drop  = in_valid & w_full;
  assign w_pop   = out_ready & ~w_empty;

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_flags, F};
    end
  end

  // Pointers are AW bits wide, so they wrap at DEPTH-1 -> 0 by themselves.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as clr_err leaves overrun set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_err) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_data  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign out_flags = w_empty ? '0 : w_head[DATA_W+5:DATA_W];
  assign out_valid = ~w_empty;
  assign in_ready  = ~w_full;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overrun   = r_overrun;

`ifdef ALU_FLAG_STATS_EN
  logic [7:0] r_carry_cnt;
  logic [7:0] r_ovf_cnt;

  // in_flags[1] is carry_out, in_flags[0] is over_flow. Clear beats increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_carry_cnt <= 8'h00;
      r_ovf_cnt   <= 8'h00;
    end else if (clr_err) begin
      r_carry_cnt <= 8'h00;
      r_ovf_cnt   <= 8'h00;
    end else if (w_push) begin
      if (in_flags[1] && (r_carry_cnt != 8'hFF)) r_carry_cnt <= r_carry_cnt + 8'h01;
      if (in_flags[0] && (r_ovf_cnt != 8'hFF))   r_ovf_cnt   <= r_ovf_cnt + 8'h01;
    end
  end

  assign carry_cnt = r_carry_cnt;
  assign ovf_cnt   = r_ovf_cnt;
`else
  assign carry_cnt = 8'h00;
  assign ovf_cnt   = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: a table of per-cycle vectors with
// hand-computed head/count/flag expectations, plus hand-written sequences
// for the no-bypass latency, asynchronous reset and the stats counters.

module tb_alu_result_fifo;

  logic       CLK;
  logic       RST_N;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] F;
  logic [5:0] in_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [5:0] out_flags;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       clr_err;
  logic [7:0] carry_cnt;
  logic [7:0] ovf_cnt;

  int n_vec;
  int n_err;

  alu_result_fifo #(
    .DATA_W(8),
    .DEPTH (4),
    .AW    (2)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .F        (F),
    .in_flags (in_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_flags(out_flags),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .carry_cnt(carry_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       iv;
    logic [7:0] f;
    logic [5:0] fl;
    logic       ord;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [5:0] e_flags;
    logic [2:0] e_count;
    logic       e_full;
    logic       e_ovr;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic e_valid, input logic [7:0] e_data,
                           input logic [5:0] e_flags, input logic [2:0] e_count,
                           input logic e_full, input logic e_ovr);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(e_data));
    chk({tag, ".out_flags"}, 32'(out_flags), 32'(e_flags));
    chk({tag, ".count"},     32'(count),     32'(e_count));
    chk({tag, ".full"},      32'(full),      32'(e_full));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!e_full));
    chk({tag, ".empty"},     32'(empty),     32'(e_count == 3'd0));
    chk({tag, ".overrun"},   32'(overrun),   32'(e_ovr));
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    F         = 8'h00;
    in_flags  = 6'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //          iv  f      fl         ord  clr  val data   flags      cnt  full ovr
    vecs[0]  = '{1, 8'hA9, 6'b100010, 0, 0,  1, 8'hA9, 6'b100010, 3'd1, 0, 0};
    vecs[1]  = '{0, 8'h00, 6'b000000, 1, 0,  0, 8'h00, 6'b000000, 3'd0, 0, 0};
    vecs[2]  = '{1, 8'h11, 6'b000001, 0, 0,  1, 8'h11, 6'b000001, 3'd1, 0, 0};
    vecs[3]  = '{1, 8'h22, 6'b000010, 0, 0,  1, 8'h11, 6'b000001, 3'd2, 0, 0};
    vecs[4]  = '{1, 8'h33, 6'b000100, 0, 0,  1, 8'h11, 6'b000001, 3'd3, 0, 0};
    vecs[5]  = '{1, 8'h44, 6'b001000, 0, 0,  1, 8'h11, 6'b000001, 3'd4, 1, 0};
    vecs[6]  = '{1, 8'h55, 6'b111111, 0, 0,  1, 8'h11, 6'b000001, 3'd4, 1, 1};
    vecs[7]  = '{0, 8'h00, 6'b000000, 1, 0,  1, 8'h22, 6'b000010, 3'd3, 0, 1};
    vecs[8]  = '{0, 8'h00, 6'b000000, 1, 0,  1, 8'h33, 6'b000100, 3'd2, 0, 1};
    vecs[9]  = '{1, 8'h66, 6'b010000, 1, 0,  1, 8'h44, 6'b001000, 3'd2, 0, 1};
    vecs[10] = '{1, 8'h77, 6'b100000, 1, 0,  1, 8'h66, 6'b010000, 3'd2, 0, 1};
    vecs[11] = '{1, 8'h88, 6'b000011, 1, 0,  1, 8'h77, 6'b100000, 3'd2, 0, 1};
    vecs[12] = '{1, 8'h99, 6'b000000, 1, 0,  1, 8'h88, 6'b000011, 3'd2, 0, 1};
    vecs[13] = '{1, 8'hAA, 6'b000101, 1, 0,  1, 8'h99, 6'b000000, 3'd2, 0, 1};
    vecs[14] = '{1, 8'hBB, 6'b001010, 1, 0,  1, 8'hAA, 6'b000101, 3'd2, 0, 1};
    vecs[15] = '{0, 8'h00, 6'b000000, 0, 1,  1, 8'hAA, 6'b000101, 3'd2, 0, 0};
    vecs[16] = '{0, 8'h00, 6'b000000, 1, 0,  1, 8'hBB, 6'b001010, 3'd1, 0, 0};
    vecs[17] = '{0, 8'h00, 6'b000000, 1, 0,  0, 8'h00, 6'b000000, 3'd0, 0, 0};
    vecs[18] = '{0, 8'h00, 6'b000000, 1, 0,  0, 8'h00, 6'b000000, 3'd0, 0, 0};
    vecs[19] = '{1, 8'hC1, 6'b000001, 1, 0,  1, 8'hC1, 6'b000001, 3'd1, 0, 0};
    vecs[20] = '{1, 8'hD2, 6'b000010, 1, 0,  1, 8'hD2, 6'b000010, 3'd1, 0, 0};
    vecs[21] = '{1, 8'hE1, 6'b010101, 0, 0,  1, 8'hD2, 6'b000010, 3'd2, 0, 0};
    vecs[22] = '{1, 8'hE2, 6'b000000, 0, 0,  1, 8'hD2, 6'b000010, 3'd3, 0, 0};
    vecs[23] = '{1, 8'hE3, 6'b000000, 0, 0,  1, 8'hD2, 6'b000010, 3'd4, 1, 0};
    vecs[24] = '{1, 8'hE4, 6'b111111, 1, 1,  1, 8'hE1, 6'b010101, 3'd3, 0, 1};
    vecs[25] = '{0, 8'h00, 6'b000000, 0, 1,  1, 8'hE1, 6'b010101, 3'd3, 0, 0};

    idle();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_state("reset", 1'b0, 8'h00, 6'b0, 3'd0, 1'b0, 1'b0);
    chk("reset.carry_cnt", 32'(carry_cnt), 32'h0);
    chk("reset.ovf_cnt",   32'(ovf_cnt),   32'h0);
    RST_N = 1'b1;

    // No bypass: input data must not appear at the output before the edge.
    in_valid = 1'b1;
    F        = 8'h5A;
    in_flags = 6'b111000;
    #1;
    chk("nobypass.out_valid", 32'(out_valid), 32'h0);
    chk("nobypass.out_data",  32'(out_data),  32'h0);
    @(posedge CLK);
    #1;
    chk_state("latency", 1'b1, 8'h5A, 6'b111000, 3'd1, 1'b0, 1'b0);
    @(negedge CLK);
    idle();
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk_state("drain5a", 1'b0, 8'h00, 6'b0, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 26; i++) begin
      @(negedge CLK);
      in_valid  = vecs[i].iv;
      F         = vecs[i].f;
      in_flags  = vecs[i].fl;
      out_ready = vecs[i].ord;
      clr_err   = vecs[i].clr;
      @(posedge CLK);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_flags,
                vecs[i].e_count, vecs[i].e_full, vecs[i].e_ovr);
`ifndef ALU_FLAG_STATS_EN
      chk($sformatf("vec%0d.carry_cnt", i), 32'(carry_cnt), 32'h0);
      chk($sformatf("vec%0d.ovf_cnt", i),   32'(ovf_cnt),   32'h0);
`endif
    end

    // Asynchronous reset mid-stream at count=3, well away from any edge.
    @(negedge CLK);
    idle();
    #2;
    RST_N = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 8'h00, 6'b0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

`ifdef ALU_FLAG_STATS_EN
    // 300 accepted pushes with carry_out=1, draining concurrently.
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      in_valid  = 1'b1;
      F         = 8'(i);
      in_flags  = 6'b000010;
      out_ready = 1'b1;
    end
    @(negedge CLK);
    idle();
    chk("stats.carry_sat", 32'(carry_cnt), 32'hFF);
    chk("stats.ovf_zero",  32'(ovf_cnt),   32'h00);
    chk("stats.overrun",   32'(overrun),   32'h0);
    clr_err = 1'b1;
    @(negedge CLK);
    idle();
    chk("stats.carry_clr", 32'(carry_cnt), 32'h00);
    chk("stats.ovf_clr",   32'(ovf_cnt),   32'h00);
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      in_valid  = 1'b1;
      F         = 8'(i);
      in_flags  = 6'b000011;
      out_ready = 1'b1;
    end
    @(negedge CLK);
    idle();
    chk("nostats.carry_cnt", 32'(carry_cnt), 32'h00);
    chk("nostats.ovf_cnt",   32'(ovf_cnt),   32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
